// File: rtl/coherence_pkg.sv
// Shared coherence-bus types: word type, L2 responder state encoding and CPU count.
package coherence_pkg;

  localparam int unsigned CPUS = 2;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    L2_FREE   = 2'd0,
    L2_BUSY   = 2'd1,
    L2_ACCESS = 2'd2,
    L2_ERROR  = 2'd3
  } l2_state_t;

endpackage

// File: rtl/l2_responder_sram.sv
// l2_sram: single-port word-addressed synchronous RAM, registered read data, no reset.
module l2_sram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             CLK,
  input  logic             wen,
  input  logic             ren,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge CLK) begin
    if (wen) mem_q[idx] <= wdata;
    if (ren) rdata <= mem_q[idx];
  end

endmodule

// File: rtl/l2_responder.sv
// L2-side coherence-bus endpoint: FSM, latency counter and SRAM front end.
// Optional per-operation counters when L2_RESPONDER_STATS_EN is defined.
module l2_responder
  import coherence_pkg::*;
#(
  parameter int unsigned LAT         = 4,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        l2REN,
  input  logic        l2WEN,
  input  logic [31:0] l2addr,
  input  logic [31:0] l2store,
  output logic [1:0]  l2state,
  output logic [31:0] l2load
`ifdef L2_RESPONDER_STATS_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [31:0] err_count
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LAT > 0) ? LAT - 1 : 0);

  l2_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  word_t            data_q, data_d;
  logic             wr_q, wr_d;
  word_t            load_q, load_d;

  word_t            word_off;
  logic             req_ok;
  logic             enter_access;
  logic             sram_wen, sram_ren;
  word_t            sram_rdata;

  // Unsigned subtract: addresses below BASE_ADDR wrap high and fail the range check.
  assign word_off = (l2addr - BASE_ADDR) >> 2;
  assign req_ok   = (l2REN ^ l2WEN) && (l2addr[1:0] == 2'b00) &&
                    (word_off < DEPTH_WORDS);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    wr_d    = wr_q;
    unique case (state_q)
      L2_FREE: begin
        if (req_ok) begin
          idx_d   = word_off[IDX_W-1:0];
          data_d  = l2store;
          wr_d    = l2WEN;
          cnt_d   = CNT_INIT;
          state_d = (LAT == 0) ? L2_ACCESS : L2_BUSY;
        end else if (l2REN || l2WEN) begin
          state_d = L2_ERROR;
        end
      end
      L2_BUSY: begin
        if (cnt_q == '0) state_d = L2_ACCESS;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = L2_FREE;
    endcase
  end

  // SRAM is driven from next-state values so the access lands on the edge entering
  // ACCESS for both the FREE->ACCESS (LAT=0) and BUSY->ACCESS paths.
  assign enter_access = (state_d == L2_ACCESS) && !RST;
  assign sram_wen     = enter_access && wr_d;
  assign sram_ren     = enter_access && !wr_d;

  l2_sram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_sram (
    .CLK   (CLK),
    .wen   (sram_wen),
    .ren   (sram_ren),
    .idx   (idx_d),
    .wdata (data_d),
    .rdata (sram_rdata)
  );

  // Registered SRAM data is presented during the read's ACCESS cycle and retained after.
  always_comb begin
    load_d = load_q;
    if (state_q == L2_ACCESS && !wr_q) load_d = sram_rdata;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= L2_FREE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      load_q  <= load_d;
    end
  end

  assign l2state = state_q;
  assign l2load  = load_d;

`ifdef L2_RESPONDER_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q, err_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      if (sram_ren)               rd_cnt_q  <= rd_cnt_q + 32'd1;
      if (sram_wen)               wr_cnt_q  <= wr_cnt_q + 32'd1;
      if (state_d == L2_ERROR)    err_cnt_q <= err_cnt_q + 32'd1;
    end
  end

  assign rd_count  = rd_cnt_q;
  assign wr_count  = wr_cnt_q;
  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_l2_responder.sv
// Bench for l2_responder: LAT=4 instance (base 0, 1024 words) and LAT=0 instance
// (base 0x100, 256 words), directed cases then randomized traffic against a model.
module tb_l2_responder;
  import coherence_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic        ren   [2];
  logic        wen   [2];
  logic [31:0] addr  [2];
  logic [31:0] store [2];
  logic [1:0]  st    [2];
  logic [31:0] ld    [2];
`ifdef L2_RESPONDER_STATS_EN
  logic [31:0] rdc [2];
  logic [31:0] wrc [2];
  logic [31:0] erc [2];
`endif

  l2_responder #(.LAT(4), .DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000)) u_lat4 (
    .CLK(clk), .RST(rst[0]), .l2REN(ren[0]), .l2WEN(wen[0]),
    .l2addr(addr[0]), .l2store(store[0]), .l2state(st[0]), .l2load(ld[0])
`ifdef L2_RESPONDER_STATS_EN
    , .rd_count(rdc[0]), .wr_count(wrc[0]), .err_count(erc[0])
`endif
  );

  l2_responder #(.LAT(0), .DEPTH_WORDS(256), .BASE_ADDR(32'h0000_0100)) u_lat0 (
    .CLK(clk), .RST(rst[1]), .l2REN(ren[1]), .l2WEN(wen[1]),
    .l2addr(addr[1]), .l2store(store[1]), .l2state(st[1]), .l2load(ld[1])
`ifdef L2_RESPONDER_STATS_EN
    , .rd_count(rdc[1]), .wr_count(wrc[1]), .err_count(erc[1])
`endif
  );

  // Reference model
  int unsigned lat_m   [2] = '{4, 0};
  longint      base_m  [2] = '{64'h0, 64'h100};
  longint      depth_m [2] = '{1024, 256};
  logic [31:0] mem_m [longint];
  logic [31:0] exp_ld [2];
  int unsigned n_rd [2], n_wr [2], n_err [2];
  logic [31:0] wq0 [$];
  logic [31:0] wq1 [$];

  int tests = 0;
  int fails = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT in FREE; returns at a negedge in FREE.
  task automatic txn(int s, bit r, bit w, logic [31:0] a, logic [31:0] d, bit mutate);
    longint off;
    bit ok;
    int unsigned n;
    longint key;
    ren[s] = r; wen[s] = w; addr[s] = a; store[s] = d;
    off = longint'(a) - base_m[s];
    ok  = (r != w) && (a[1:0] == 2'b00) && (off >= 0) && (off < 4 * depth_m[s]);
    key = (longint'(s) << 32) + (off >>> 2);
    n   = ok ? lat_m[s] : 0;
    for (int i = 0; i < int'(n); i++) begin
      @(negedge clk);
      chk($sformatf("s%0d busy%0d a=%08h", s, i, a), 32'(st[s]), 32'(L2_BUSY));
      if (mutate) begin
        addr[s]  = $urandom;
        store[s] = $urandom;
        ren[s]   = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    if (ok) begin
      if (w) begin
        mem_m[key] = d;
        n_wr[s]++;
        if (s == 0) wq0.push_back(a); else wq1.push_back(a);
      end else begin
        exp_ld[s] = mem_m[key];
        n_rd[s]++;
      end
      chk($sformatf("s%0d access a=%08h", s, a), 32'(st[s]), 32'(L2_ACCESS));
    end else begin
      n_err[s]++;
      chk($sformatf("s%0d error a=%08h", s, a), 32'(st[s]), 32'(L2_ERROR));
    end
    chk($sformatf("s%0d load a=%08h", s, a), ld[s], exp_ld[s]);
    ren[s] = 1'b0; wen[s] = 1'b0;
    @(negedge clk);
    chk($sformatf("s%0d free a=%08h", s, a), 32'(st[s]), 32'(L2_FREE));
    chk($sformatf("s%0d hold a=%08h", s, a), ld[s], exp_ld[s]);
  endtask

`ifdef L2_RESPONDER_STATS_EN
  task automatic chk_stats(int s);
    chk($sformatf("s%0d rd_count", s), rdc[s], 32'(n_rd[s]));
    chk($sformatf("s%0d wr_count", s), wrc[s], 32'(n_wr[s]));
    chk($sformatf("s%0d err_count", s), erc[s], 32'(n_err[s]));
  endtask
`endif

  initial begin
    int s, kind;
    logic [31:0] a;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; ren[i] = 1'b0; wen[i] = 1'b0; addr[i] = '0; store[i] = '0;
      exp_ld[i] = '0; n_rd[i] = 0; n_wr[i] = 0; n_err[i] = 0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("s%0d reset state", i), 32'(st[i]), 32'(L2_FREE));
      chk($sformatf("s%0d reset load", i), ld[i], 32'h0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);

    // LAT=4 write/read
    txn(0, 0, 1, 32'h40, 32'hDEAD_BEEF, 0);
    txn(0, 1, 0, 32'h40, 32'h0, 0);
    // LAT=0 write/read at word 0, back-to-back
    txn(1, 0, 1, 32'h100, 32'hCAFE_F00D, 0);
    txn(1, 1, 0, 32'h100, 32'h0, 0);

    // Error cases: nothing changes
    txn(0, 1, 1, 32'h40, 32'h1111_1111, 0);
    txn(0, 0, 1, 32'h42, 32'h2222_2222, 0);
    txn(0, 1, 0, 32'h2, 32'h0, 0);
    txn(0, 0, 1, 32'h1000, 32'h3333_3333, 0);
    txn(0, 1, 0, 32'h40, 32'h0, 0);
    txn(1, 0, 1, 32'h0, 32'h4444_4444, 0);
    txn(1, 1, 0, 32'h100 + 32'h400, 32'h0, 0);
    txn(1, 1, 0, 32'h100, 32'h0, 0);

    // Inputs changed while BUSY must not disturb the latched write
    txn(0, 0, 1, 32'h10, 32'hA5A5_0010, 1);
    txn(0, 1, 0, 32'h10, 32'h0, 0);

    // Reset during BUSY drops the pending write
    txn(0, 0, 1, 32'h20, 32'h0000_5555, 0);
    ren[0] = 1'b0; wen[0] = 1'b1; addr[0] = 32'h20; store[0] = 32'h0000_1234;
    @(negedge clk);
    chk("rst busy0", 32'(st[0]), 32'(L2_BUSY));
    @(negedge clk);
    chk("rst busy1", 32'(st[0]), 32'(L2_BUSY));
    rst[0] = 1'b1;
    @(negedge clk);
    chk("rst mid state", 32'(st[0]), 32'(L2_FREE));
    chk("rst mid load", ld[0], 32'h0);
    exp_ld[0] = '0; n_rd[0] = 0; n_wr[0] = 0; n_err[0] = 0;
`ifdef L2_RESPONDER_STATS_EN
    chk_stats(0);
`endif
    rst[0] = 1'b0; wen[0] = 1'b0;
    txn(0, 1, 0, 32'h20, 32'h0, 0);

    // Randomized traffic
    for (int it = 0; it < 80; it++) begin
      s    = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 9));
      if (kind >= 4 && kind <= 7 && ((s == 0) ? wq0.size() : wq1.size()) == 0) kind = 0;
      if (kind <= 3) begin
        a = 32'(base_m[s] + 4 * longint'($urandom_range(0, 32'(depth_m[s] - 1))));
        txn(s, 0, 1, a, $urandom, 1'($urandom_range(0, 1)));
      end else if (kind <= 7) begin
        a = (s == 0) ? wq0[$urandom_range(0, wq0.size() - 1)]
                     : wq1[$urandom_range(0, wq1.size() - 1)];
        txn(s, 1, 0, a, $urandom, 1'($urandom_range(0, 1)));
      end else if (kind == 8) begin
        txn(s, 1, 1, 32'(base_m[s]), $urandom, 0);
      end else begin
        a = $urandom;
        if ($urandom_range(0, 1) == 1) a = 32'(base_m[s] + 4 * depth_m[s]) + (a & 32'hFC);
        txn(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)) | 1'b1, a, $urandom, 0);
      end
    end

`ifdef L2_RESPONDER_STATS_EN
    chk_stats(0);
    chk_stats(1);
    rst[0] = 1'b1; rst[1] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_rd[i] = 0; n_wr[i] = 0; n_err[i] = 0;
      chk_stats(i);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
